// File: rtl/instr_encoder.sv
// Instruction encoder: packs a field set into a 32-bit word, buffers it in a small FIFO
// and streams the words to instruction memory at an auto-incrementing word address.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_class,
  input  logic [4:0]        op_code,
  input  logic [2:0]        rd,
  input  logic [2:0]        rn,
  input  logic [2:0]        rm,
  input  logic [3:0]        cond,
  input  logic [15:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              clr_done,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_illegal,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [31:0]       HALT_WORD = 32'hD000_0000;
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [31:0]       fifo_mem [FIFO_DEPTH];

  logic        legal;
  logic [31:0] enc_word;
  logic        fifo_full, fifo_empty;
  logic        fire, push, pop;
  logic [31:0] head_word;

  always_comb begin
    legal = 1'b0;
    case (op_class)
      2'b00:   legal = (op_code <= 5'd5) ||
                       (op_code >= 5'd17 && op_code <= 5'd21) ||
                       (op_code >= 5'd25 && op_code <= 5'd29);
      2'b01:   legal = (op_code >= 5'd17 && op_code <= 5'd22) ||
                       (op_code >= 5'd25 && op_code <= 5'd29);
      2'b10:   legal = (op_code <= 5'd1);
      default: legal = (op_code == 5'd0) || (op_code == 5'd1) || (op_code == 5'd2) ||
                       (op_code == 5'd4) || (op_code == 5'd8);
    endcase
  end

  always_comb begin
    enc_word = {op_class, op_code, 25'b0};
    case (op_class)
      2'b00: begin
        enc_word[24:22] = rd;
        // mov/movt carry no source register
        enc_word[21:19] = (op_code[4:1] == 4'b0000) ? 3'b000 : rn;
        enc_word[15:0]  = imm;
      end
      2'b01: begin
        enc_word[24:22] = rd;
        enc_word[21:19] = rn;
        enc_word[18:16] = rm;
      end
      2'b10: begin
        enc_word[24:22] = rd;
        enc_word[21:19] = rn;
        enc_word[15:0]  = imm;
      end
      default: begin
        case (op_code)
          5'd0: enc_word[15:0] = imm;
          5'd1: begin
            enc_word[24:21] = cond;
            enc_word[15:0]  = imm;
          end
          5'd2: begin
            enc_word[21:19] = rn;
            enc_word[15:0]  = imm;
          end
          default: ;
        endcase
      end
    endcase
  end

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign in_ready   = ~rst & ~fifo_full & (state_q != ST_DONE);
  assign fire       = in_valid & in_ready;
  assign push       = fire & legal;
  assign head_word  = fifo_mem[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (addr_load && fifo_empty) addr_d = addr_in;
        if (!fifo_empty) begin
          pop     = 1'b1;
          wdata_d = head_word;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          addr_d = addr_q + ADDR_ONE;
          if (wdata_q == HALT_WORD) begin
            state_d = ST_DONE;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            wdata_d = head_word;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (clr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= fire & ~legal;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign mem_req     = (state_q == ST_REQ);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign err_illegal = err_q;
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized traffic scored against
// a queue-based reference of accepted words and expected write addresses.
module tb_instr_encoder;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, addr_load, clr_done, mem_req, mem_ack, err_illegal, done;
  logic [1:0]  op_class;
  logic [4:0]  op_code;
  logic [2:0]  rd, rn, rm;
  logic [3:0]  cond;
  logic [15:0] imm, addr_in, mem_addr;
  logic [31:0] mem_wdata;

  int checks = 0, failures = 0, wr_count = 0, got_err = 0, exp_err = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_addr = '0;

  typedef struct {
    logic [1:0]  cls;
    logic [4:0]  op;
    logic [2:0]  rd, rn, rm;
    logic [3:0]  cond;
    logic [15:0] imm;
  } fs_t;

  instr_encoder #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .op_code(op_code), .rd(rd), .rn(rn), .rm(rm),
    .cond(cond), .imm(imm), .addr_load(addr_load), .addr_in(addr_in),
    .clr_done(clr_done), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err_illegal(err_illegal), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_legal(input int c, input int o);
    case (c)
      0:       return (o <= 5) || (o >= 17 && o <= 21) || (o >= 25 && o <= 29);
      1:       return (o >= 17 && o <= 22) || (o >= 25 && o <= 29);
      2:       return (o <= 1);
      default: return (o == 0) || (o == 1) || (o == 2) || (o == 4) || (o == 8);
    endcase
  endfunction

  function automatic logic [31:0] ref_encode(input fs_t f);
    longint w;
    longint c = longint'(f.cls), o = longint'(f.op);
    w = c * (64'd1 << 30) + o * (64'd1 << 25);
    case (c)
      0: w += longint'(f.rd) * (1 << 22) + ((o < 2) ? 0 : longint'(f.rn) * (1 << 19)) + longint'(f.imm);
      1: w += longint'(f.rd) * (1 << 22) + longint'(f.rn) * (1 << 19) + longint'(f.rm) * (1 << 16);
      2: w += longint'(f.rd) * (1 << 22) + longint'(f.rn) * (1 << 19) + longint'(f.imm);
      default: begin
        if (o == 0) w += longint'(f.imm);
        else if (o == 1) w += longint'(f.cond) * (1 << 21) + longint'(f.imm);
        else if (o == 2) w += longint'(f.rn) * (1 << 19) + longint'(f.imm);
      end
    endcase
    return w[31:0];
  endfunction

  function automatic fs_t mk(input int c, input int o, input int d, input int n,
                             input int m, input int cd, input int im);
    fs_t f;
    f.cls = 2'(c); f.op = 5'(o); f.rd = 3'(d); f.rn = 3'(n); f.rm = 3'(m);
    f.cond = 4'(cd); f.imm = 16'(im);
    return f;
  endfunction

  function automatic fs_t rand_fs(input bit want_legal);
    fs_t f;
    f = mk($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 65535));
    if (want_legal) begin
      for (int k = 0; k < 200 && !ref_legal(int'(f.cls), int'(f.op)); k++) f.op = 5'($urandom_range(0, 31));
      if (!ref_legal(int'(f.cls), int'(f.op))) begin f.cls = 2'd0; f.op = 5'd17; end
    end
    if (f.cls == 2'd3 && f.op == 5'd8) f.op = 5'd4;  // keep random traffic out of DONE
    return f;
  endfunction

  // Scoreboard update at the active edge, before the design's registers change.
  task automatic observe();
    fs_t f;
    if (rst) begin
      exp_q.delete();
      exp_addr = '0;
    end else begin
      if (addr_load) exp_addr = addr_in;
      if (mem_req && mem_ack) begin
        wr_count++;
        $display("write addr=%h data=%h", mem_addr, mem_wdata);
        check_eq("wr_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_eq("wr_data", mem_wdata, exp_q.pop_front());
        check_eq("wr_addr", 32'(mem_addr), 32'(exp_addr));
        exp_addr = exp_addr + 16'd1;
      end
      if (in_valid && in_ready) begin
        f = mk(op_class, op_code, rd, rn, rm, cond, imm);
        if (ref_legal(int'(op_class), int'(op_code))) exp_q.push_back(ref_encode(f));
        else exp_err++;
      end
      if (err_illegal) got_err++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    observe();
    @(negedge clk);
  endtask

  task automatic send(input fs_t f, output bit acc);
    in_valid = 1'b1;
    op_class = f.cls; op_code = f.op; rd = f.rd; rn = f.rn; rm = f.rm; cond = f.cond; imm = f.imm;
    acc = in_ready;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!mem_req && n < max) begin step(); n++; end
    check_eq("wait_req", 32'(mem_req), 32'd1);
  endtask

  task automatic ack_one();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic load_addr(input logic [15:0] a);
    addr_in = a; addr_load = 1'b1;
    step();
    addr_load = 1'b0;
  endtask

  initial begin
    bit acc;
    int accepted, wc0, n;
    fs_t f;
    rst = 1'b1; in_valid = 0; addr_load = 0; clr_done = 0; mem_ack = 0;
    op_class = 0; op_code = 0; rd = 0; rn = 0; rm = 0; cond = 0; imm = 0; addr_in = 0;
    @(negedge clk); step();
    check_eq("rst_in_ready", 32'(in_ready), 0);
    check_eq("rst_mem_req", 32'(mem_req), 0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_err", 32'(err_illegal), 0);
    check_eq("rst_done", 32'(done), 0);
    rst = 1'b0;
    step();
    check_eq("post_rst_in_ready", 32'(in_ready), 1);

    // add-imm with a loaded start address and the two-edge request latency
    load_addr(16'h0100);
    send(mk(0, 17, 3, 2, 0, 0, 16'h0010), acc);
    check_eq("addimm_acc", 32'(acc), 1);
    check_eq("addimm_req_e1", 32'(mem_req), 0);
    step();
    check_eq("addimm_req_e2", 32'(mem_req), 1);
    check_eq("addimm_wdata", mem_wdata, 32'h22D00010);
    check_eq("addimm_addr", 32'(mem_addr), 32'h0100);
    ack_one();
    check_eq("addimm_idle", 32'(mem_req), 0);
    check_eq("addimm_addr_inc", 32'(mem_addr), 32'h0101);

    send(mk(3, 1, 0, 0, 0, 4'hA, 16'hFFFC), acc);
    wait_req(5);
    check_eq("bcond_wdata", mem_wdata, 32'hC340FFFC);
    ack_one();

    send(mk(1, 0, 1, 1, 1, 0, 0), acc);
    check_eq("illegal_pulse", 32'(err_illegal), 1);
    step();
    check_eq("illegal_pulse_end", 32'(err_illegal), 0);
    step();
    check_eq("illegal_no_req", 32'(mem_req), 0);
    check_eq("illegal_ready", 32'(in_ready), 1);

    // back-pressure: one word in the write register plus a full FIFO
    wc0 = wr_count; accepted = 0;
    for (int i = 0; i < 7; i++) begin
      send(rand_fs(1'b1), acc);
      accepted += int'(acc);
    end
    check_eq("bp_accepted", 32'(accepted), 5);
    check_eq("bp_ready_low", 32'(in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_req", 32'(mem_req), 1);
      ack_one();
    end
    check_eq("bp_writes", 32'(wr_count - wc0), 5);
    check_eq("bp_idle", 32'(mem_req), 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        f = rand_fs($urandom_range(0, 4) != 0);
        in_valid = 1'b1;
        op_class = f.cls; op_code = f.op; rd = f.rd; rn = f.rn; rm = f.rm; cond = f.cond; imm = f.imm;
      end else begin
        in_valid = 1'b0;
      end
      mem_ack = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; mem_ack = 1'b1; n = 0;
    while ((exp_q.size() != 0 || mem_req) && n < 60) begin step(); n++; end
    mem_ack = 1'b0;
    step(); step();
    check_eq("rand_drained", 32'(exp_q.size()), 0);
    check_eq("rand_err_count", 32'(got_err), 32'(exp_err));

    // address wrap and HALT
    load_addr(16'hFFFF);
    send(mk(3, 4, 0, 0, 0, 0, 0), acc);
    send(mk(3, 8, 0, 0, 0, 0, 0), acc);
    wait_req(5);
    check_eq("wrap_nop", mem_wdata, 32'hC8000000);
    check_eq("wrap_nop_addr", 32'(mem_addr), 32'hFFFF);
    ack_one();
    check_eq("wrap_b2b_req", 32'(mem_req), 1);
    check_eq("wrap_halt", mem_wdata, 32'hD0000000);
    check_eq("wrap_halt_addr", 32'(mem_addr), 0);
    ack_one();
    check_eq("halt_done", 32'(done), 1);
    check_eq("halt_ready", 32'(in_ready), 0);
    check_eq("halt_req", 32'(mem_req), 0);
    send(rand_fs(1'b1), acc);
    check_eq("done_blocks", 32'(acc), 0);
    clr_done = 1'b1;
    step();
    clr_done = 1'b0;
    check_eq("clr_done", 32'(done), 0);
    check_eq("clr_ready", 32'(in_ready), 1);

    // reset while a request is pending and three words are buffered
    for (int i = 0; i < 4; i++) send(rand_fs(1'b1), acc);
    check_eq("midrst_req_before", 32'(mem_req), 1);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_req_now", 32'(mem_req), 0);
    check_eq("midrst_addr_now", 32'(mem_addr), 0);
    step(); step();
    rst = 1'b0;
    wc0 = wr_count; mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) step();
    mem_ack = 1'b0;
    check_eq("midrst_no_writes", 32'(wr_count - wc0), 0);
    check_eq("midrst_addr", 32'(mem_addr), 0);
    check_eq("midrst_ready", 32'(in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  FIFO_DEPTH  4   encoded-word buffer entries, power of 2
  ADDR_W      16  instruction-memory word-address width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
  clk          in   1       sole clock, rising edge
  rst          in   1       asynchronous, active-high reset
  in_valid     in   1       field set valid
  in_ready     out  1       field set accepted when in_valid&in_ready at edge
  op_class     in   2       instruction class -> bits 31:30
  op_code      in   5       second-level opcode -> bits 29:25
  rd           in   3       destination -> bits 24:22
  rn           in   3       operand 1 / pointer -> bits 21:19
  rm           in   3       operand 2 -> bits 18:16
  cond         in   4       branch condition -> bits 24:21
  imm          in   16      immediate/offset -> bits 15:0
  addr_load    in   1       load start address
  addr_in      in   ADDR_W  start address
  clr_done     in   1       leave DONE state
  mem_req      out  1       write request to instruction memory
  mem_ack      in   1       write accepted at edge while mem_req=1
  mem_addr     out  ADDR_W  write word address
  mem_wdata    out  32      encoded instruction
  err_illegal  out  1       one-cycle pulse: illegal field set dropped
  done         out  1       HALT word written

Function
REQ-003 Legal (op_class, op_code): 00 with 00000-00101, 10001-10101, 11001-11101; 01 with 10001-10110, 11001-11101; 10 with 00000 (load), 00001 (store); 11 with 00000 (B), 00001 (B.cond), 00010 (BR), 00100 (NOP), 01000 (HALT).
REQ-004 Word SHALL be {op_class, op_code} in 31:25; field placement per class: 00 -> rd, rn, imm, bits 18:16=0; 01 -> rd, rn, rm, bits 15:0=0; 10 -> rd, rn, imm, bits 18:16=0.
REQ-005 Class 11: B -> imm only; B.cond -> cond in 24:21, imm; BR -> rn, imm; NOP=0xC8000000; HALT=0xD0000000; all unlisted bits 0.
REQ-006 Class 00 opcodes 00000/00001 (mov/movt) SHALL force bits 21:19 to 0.
REQ-007 Illegal field set, when handshaken, SHALL be dropped and err_illegal SHALL pulse high the following cycle.
REQ-008 Legal handshaken word SHALL be pushed into the FIFO at that edge.
REQ-009 in_ready = ~fifo_full & ~done; SHALL not depend on same-cycle pop.
REQ-010 Write FSM states: IDLE, REQ, DONE.
REQ-011 IDLE & FIFO non-empty: at next edge pop head into mem_wdata register, mem_req=1, go REQ (handshake-to-mem_req latency 2 edges).
REQ-012 REQ: mem_req, mem_addr, mem_wdata SHALL hold stable until mem_ack=1 at an edge.
REQ-013 At ack edge: mem_addr += 1, wrapping all-ones -> 0; if written word is HALT go DONE, mem_req=0; else if FIFO non-empty pop next (back-to-back, mem_req stays 1); else IDLE, mem_req=0.
REQ-014 DONE: done=1, in_ready=0, FIFO contents retained; clr_done SHALL return to IDLE, done=0 at next edge; clr_done outside DONE ignored.
REQ-015 addr_load SHALL load mem_addr from addr_in only when state IDLE and FIFO empty; otherwise ignored.
REQ-016 Push and pop in same cycle SHALL leave occupancy unchanged; capacity with mem_ack held low = FIFO_DEPTH+1 words.

Reset
REQ-017 rst=1 SHALL immediately force: state IDLE, FIFO empty, mem_req=0, mem_addr=0, mem_wdata=0, err_illegal=0, done=0, in_ready=0 while rst=1, in_ready=1 first cycle after release.
REQ-018 Reset mid-request SHALL abandon the pending word without a further mem_req.

Verification
REQ-019 Scenario add-imm: class 00, op 10001, rd 3, rn 2, imm 0x0010, addr_load 0x0100 -> mem_wdata 0x22D00010, mem_addr 0x0100, mem_req two edges after handshake.
REQ-020 Scenario B.cond: class 11, op 00001, cond 0xA, imm 0xFFFC -> mem_wdata 0xC340FFFC.
REQ-021 Scenario illegal: class 01, op 00000 -> err_illegal single-cycle pulse, no mem_req, FIFO unchanged.
REQ-022 Scenario back-pressure: mem_ack=0, drive 7 legal words -> exactly 5 accepted, in_ready=0; ack each -> 5 writes at consecutive addresses, order preserved.
REQ-023 Scenario wrap+HALT: addr_in 0xFFFF, write NOP then HALT -> 0xC8000000 @0xFFFF, 0xD0000000 @0x0000, done=1, in_ready=0; clr_done -> done=0, in_ready=1.
REQ-024 Scenario reset mid-op: rst asserted while mem_req=1 with 3 words buffered -> mem_req=0 same cycle, after release no writes, mem_addr=0.
